// File: rtl/decoded_bit_packer_if.sv
// Bit-in / word-out bundle for decoded_bit_packer.
// Decoded bits enter, packed words leave over valid/ready.
interface decoded_bit_packer_if #(
    parameter int W     = 8,
    parameter int DEPTH = 16
);
    localparam int FW = $clog2(DEPTH + 1);

    logic          bit_valid;
    logic          bit_in;
    logic          flush;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic          out_ready;
    logic [FW-1:0] fill_level;
    logic          overflow;

    modport master (
        output bit_valid, bit_in, flush, out_ready,
        input  out_valid, out_data, fill_level, overflow
    );

    modport slave (
        input  bit_valid, bit_in, flush, out_ready,
        output out_valid, out_data, fill_level, overflow
    );
endinterface

// File: rtl/decoded_bit_packer.sv
// Packs decoder bits into W-bit words and queues them
// in a first-word-fall-through FIFO for the UART.
module decoded_bit_packer #(
    parameter int W            = 8,
    parameter int DEPTH        = 16,
    parameter int MSB_FIRST    = 0,
    parameter int IDLE_TIMEOUT = 0
) (
    input logic                 clk,
    input logic                 rst,
    decoded_bit_packer_if.slave bus
);
    localparam int CW    = $clog2(W + 1);
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int FW    = $clog2(DEPTH + 1);
    localparam int IW    = $clog2(IDLE_TIMEOUT + 1) + 1;
    localparam int TO_M1 = (IDLE_TIMEOUT > 0) ? IDLE_TIMEOUT - 1 : 0;

    typedef enum logic {EMPTY, COLLECT} state_t;

    state_t        state;
    logic [CW-1:0] bit_cnt;
    logic [W-1:0]  sreg;
    logic [W-1:0]  word_nx;
    logic [IW-1:0] idle_cnt;
    logic          push_q;
    logic [W-1:0]  push_data;
    logic          timeout;
    logic          last_bit;
    logic          do_push;
    int            pos;

    always_comb begin
        pos     = (MSB_FIRST != 0) ? (W - 1 - int'(bit_cnt)) : int'(bit_cnt);
        word_nx = sreg;
        for (int i = 0; i < W; i++) begin
            if (bus.bit_valid && pos == i) begin
                word_nx[i] = bus.bit_in;
            end
        end
    end

    assign timeout  = (IDLE_TIMEOUT != 0) && (state == COLLECT)
                   && !bus.bit_valid && (idle_cnt == IW'(TO_M1));
    assign last_bit = bus.bit_valid && (int'(bit_cnt) == W - 1);
    // A same-cycle bit is merged before the flush, so one push at most.
    assign do_push  = last_bit
                   || ((bus.flush || timeout)
                       && (state == COLLECT || bus.bit_valid));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            bit_cnt   <= '0;
            sreg      <= '0;
            idle_cnt  <= '0;
            push_q    <= 1'b0;
            push_data <= '0;
        end else begin
            push_q <= do_push;
            if (do_push) begin
                push_data <= word_nx;
                state     <= EMPTY;
                bit_cnt   <= '0;
                sreg      <= '0;
                idle_cnt  <= '0;
            end else if (bus.bit_valid) begin
                state    <= COLLECT;
                bit_cnt  <= bit_cnt + CW'(1);
                sreg     <= word_nx;
                idle_cnt <= '0;
            end else if (state == COLLECT) begin
                idle_cnt <= idle_cnt + IW'(1);
            end
        end
    end

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [FW-1:0] count;
    logic          ovf;
    logic          full;
    logic          pop;
    logic          wr_en;

    assign full  = (count == FW'(DEPTH));
    assign pop   = bus.out_valid && bus.out_ready;
    assign wr_en = push_q && (!full || pop);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push_q && full && !pop) begin
                ovf <= 1'b1;
            end
            unique case ({wr_en, pop})
                2'b10:   count <= count + FW'(1);
                2'b01:   count <= count - FW'(1);
                default: count <= count;
            endcase
        end
    end

    assign bus.out_valid  = (count != '0);
    assign bus.out_data   = bus.out_valid ? mem[rd_ptr] : '0;
    assign bus.fill_level = count;
    assign bus.overflow   = ovf;
endmodule
